// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding (also used by the transmitter) and the
// oversampling constants derived from the 16x baud tick.
package uart_pkg;

  localparam int unsigned OVERSAMPLE     = 16;
  // Tick index at the middle of a bit period, counted from the detected edge.
  localparam int unsigned OVERSAMPLE_MID = OVERSAMPLE / 2 - 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset; both stages load ResetVal
//   d_i   - asynchronous input
//   q_o   - synchronized output (two clocks of latency)
module sync_2ff #(
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver feeding the RX FIFO.
// Synchronizes rx, confirms the start bit at mid-bit, samples every data bit at
// mid-period from the 16x s_tick, optionally checks parity, and strobes each word.
// Ports:
//   clk          - system clock
//   reset        - synchronous active-high reset; drops any partial word
//   s_tick       - one-cycle pulse at 16x the baud rate
//   rx           - asynchronous serial line, idles high
//   rx_done_tick - one-cycle strobe when a word (errored or not) completes
//   dout         - received word, held until the next strobe
//   frame_err    - stop bit sampled low, valid with and held after the strobe
//   parity_err   - parity mismatch, valid with and held after the strobe
//   busy         - receiver is inside a frame
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  // Tick counter must hold SB_TICK-1 (up to 31 for two stop bits).
  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] SMid  = SW'(OVERSAMPLE_MID);
  localparam logic [SW-1:0] SLast = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  localparam logic ParEn  = (PARITY_EN != 0);
  localparam logic ParOdd = (PARITY_ODD != 0);

  logic rx_s;

  sync_2ff #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_rx_state_t  state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Start edge is watched every clock, not only on s_tick.
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == SMid) begin
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;  // line went high again: glitch
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SLast) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
              state_d = ParEn ? StParity : StStop;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == SLast) begin
            p_d     = rx_s;
            s_d     = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SStop) begin
            state_d = StIdle;
            dout_d  = b_q;
            fe_d    = ~rx_s;
            pe_d    = ParEn & ((^b_q ^ p_q) != ParOdd);
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = fe_q;
  assign parity_err   = pe_q;
  assign busy         = busy_q;

endmodule
